// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, load-type encodings and the load alignment rule for the MEM/WB stage.
package mem_wb_stage_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned REG_DATA_WIDTH = 32;
    localparam int unsigned LOAD_TYPE_W    = 3;

    typedef enum logic [LOAD_TYPE_W-1:0] {
        LOAD_LW  = 3'b000,
        LOAD_LB  = 3'b001,
        LOAD_LBU = 3'b010,
        LOAD_LH  = 3'b011,
        LOAD_LHU = 3'b100
    } load_type_e;

    // Bytes never misalign, halves need an even address, words (and unknown codes) need addr_lo==0.
    function automatic logic load_misaligned(input logic [LOAD_TYPE_W-1:0] load_type,
                                             input logic [1:0]             addr_lo);
        logic mis;
        case (load_type)
            LOAD_LB, LOAD_LBU: mis = 1'b0;
            LOAD_LH, LOAD_LHU: mis = addr_lo[0];
            default:           mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-to-WB bus: MEM-side results and controls in, register-file write port and retire count out.
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_WIDTH,
    parameter int unsigned DATA_W = REG_DATA_WIDTH,
    parameter int unsigned CNT_W  = 32
);
    logic                   mem_valid;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_waddr;
    logic [DATA_W-1:0]      mem_alu_res;
    logic                   mem_is_load;
    logic [LOAD_TYPE_W-1:0] mem_load_type;
    logic [1:0]             mem_addr_lo;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   stall;
    logic                   flush;

    logic                   wb_we;
    logic [ADDR_W-1:0]      wb_waddr;
    logic [DATA_W-1:0]      wb_wdata;
    logic                   wb_valid;
    logic                   wb_misalign;
    logic [CNT_W-1:0]       retire_cnt;

    modport master (
        output mem_valid, mem_we, mem_waddr, mem_alu_res, mem_is_load,
               mem_load_type, mem_addr_lo, mem_rdata, stall, flush,
        input  wb_we, wb_waddr, wb_wdata, wb_valid, wb_misalign, retire_cnt
    );

    modport slave (
        input  mem_valid, mem_we, mem_waddr, mem_alu_res, mem_is_load,
               mem_load_type, mem_addr_lo, mem_rdata, stall, flush,
        output wb_we, wb_waddr, wb_wdata, wb_valid, wb_misalign, retire_cnt
    );

endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Load data lane extraction and sign/zero extension (combinational).
// Sub-word extraction and misalignment detection are built only with WB_LOAD_EXT_EN defined;
// otherwise every load returns the raw word and never reports misalignment.
module load_extend
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_WIDTH
) (
    input  logic [DATA_W-1:0]      rdata,
    input  logic [1:0]             addr_lo,
    input  logic [LOAD_TYPE_W-1:0] load_type,
    output logic [DATA_W-1:0]      ext_data_c,
    output logic                   misalign_c
);

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed little-endian lane, then extend according to the load type.
    always_comb begin
        byte_sel   = rdata[7:0];
        half_sel   = rdata[15:0];
        ext_data_c = rdata;
        misalign_c = load_misaligned(load_type, addr_lo);

        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase

        if (addr_lo[1]) begin
            half_sel = rdata[31:16];
        end

        case (load_type)
            LOAD_LB:  ext_data_c = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LOAD_LBU: ext_data_c = {{(DATA_W-8){1'b0}}, byte_sel};
            LOAD_LH:  ext_data_c = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LOAD_LHU: ext_data_c = {{(DATA_W-16){1'b0}}, half_sel};
            default:  ext_data_c = rdata;
        endcase
    end
`else
    logic unused_ctrl;

    // Word-only build: lane controls are not consulted.
    assign ext_data_c  = rdata;
    assign misalign_c  = 1'b0;
    assign unused_ctrl = ^{addr_lo, load_type};
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, register-file writeback port and retired-instruction counter.
// Optional feature macro: WB_LOAD_EXT_EN (byte/half load extraction and misalignment detection).
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_WIDTH,
    parameter int unsigned DATA_W = REG_DATA_WIDTH,
    parameter int unsigned CNT_W  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_wb_stage_if.slave bus
);

    logic                   valid_q;
    logic                   we_q;
    logic [ADDR_W-1:0]      waddr_q;
    logic [DATA_W-1:0]      alu_res_q;
    logic                   is_load_q;
    logic [LOAD_TYPE_W-1:0] load_type_q;
    logic [1:0]             addr_lo_q;
    logic [DATA_W-1:0]      rdata_q;
    logic [CNT_W-1:0]       retire_cnt_q;

    logic [DATA_W-1:0]      ext_data_c;
    logic                   ext_misalign_c;
    logic                   misalign_c;
    logic                   capture_misalign_c;
    logic                   retire_c;

    // Stage register: flush kills the entering instruction, stall holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            alu_res_q   <= '0;
            is_load_q   <= 1'b0;
            load_type_q <= '0;
            addr_lo_q   <= '0;
            rdata_q     <= '0;
        end else if (bus.flush) begin
            valid_q     <= 1'b0;
        end else if (!bus.stall) begin
            valid_q     <= bus.mem_valid;
            we_q        <= bus.mem_we;
            waddr_q     <= bus.mem_waddr;
            alu_res_q   <= bus.mem_alu_res;
            is_load_q   <= bus.mem_is_load;
            load_type_q <= bus.mem_load_type;
            addr_lo_q   <= bus.mem_addr_lo;
            rdata_q     <= bus.mem_rdata;
        end
    end

    // Misaligned loads are judged at capture so they never count as retired.
`ifdef WB_LOAD_EXT_EN
    assign capture_misalign_c = bus.mem_is_load & load_misaligned(bus.mem_load_type, bus.mem_addr_lo);
`else
    assign capture_misalign_c = 1'b0;
`endif

    assign retire_c = bus.mem_valid & ~bus.stall & ~bus.flush & ~capture_misalign_c;

    // Retire counter, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (retire_c) begin
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .rdata      (rdata_q),
        .addr_lo    (addr_lo_q),
        .load_type  (load_type_q),
        .ext_data_c (ext_data_c),
        .misalign_c (ext_misalign_c)
    );

    // Write port decoded purely from the stage register; $zero and misaligned loads never write.
    assign misalign_c      = valid_q & is_load_q & ext_misalign_c;
    assign bus.wb_misalign = misalign_c;
    assign bus.wb_valid    = valid_q;
    assign bus.wb_waddr    = waddr_q;
    assign bus.wb_wdata    = is_load_q ? ext_data_c : alu_res_q;
    assign bus.wb_we       = valid_q & we_q & (waddr_q != '0) & ~misalign_c;
    assign bus.retire_cnt  = retire_cnt_q;

endmodule
